demux40_loader: RTL and testbench
=================================

DEMUX40_LOADER -- requirements
Module: demux40_loader

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 40, giving the number of byte registers.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the entry width.
REQ-003 The block SHALL have parameter SEL_W, default 16, giving the select width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  begins a stream fill at entry 0.
REQ-007 s_valid  input  1  stream byte valid.
REQ-008 s_data  input  DATA_W  stream byte.
REQ-009 s_ready  output  1  stream byte accepted when s_valid and s_ready are both 1.
REQ-010 wr_en  input  1  direct-write strobe.
REQ-011 wr_sel  input  SEL_W  direct-write index; 0 selects out1 and 39 selects out40.
REQ-012 wr_data  input  DATA_W  direct-write byte.
REQ-013 out1..out40  output  DATA_W each  registered entry contents.
REQ-014 busy  output  1  high while in FILL.
REQ-015 done  output  1  one-cycle pulse when a fill completes.
REQ-016 count  output  6  number of bytes accepted in the current or last fill.
REQ-017 sel_err  output  1  one-cycle pulse for a direct write with wr_sel >= NUM_ENTRIES.

Function
REQ-018 The FSM SHALL have states IDLE, FILL and DONE.
REQ-019 IDLE SHALL move to FILL on start=1 and clear ptr and count to 0.
REQ-020 FILL SHALL assert s_ready=1 and busy=1.
REQ-021 In FILL, each accepted stream byte SHALL be written to entry ptr, then ptr and count SHALL increment.
REQ-022 In FILL, acceptance at ptr = NUM_ENTRIES-1 SHALL write the last entry and move to DONE without wrapping ptr.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and SHALL return to IDLE; count SHALL hold at 40.
REQ-024 s_ready SHALL be 0 in IDLE and DONE, and stream bytes offered there SHALL be ignored.
REQ-025 start=1 during FILL SHALL restart the fill: ptr and count go to 0 and already-written entries are retained.
REQ-026 start=1 during DONE SHALL be ignored.
REQ-027 If start=1 and a stream byte is accepted in the same FILL cycle, the byte SHALL be written to the old ptr and then ptr SHALL be cleared.
REQ-028 Direct writes SHALL be accepted in every state: wr_en=1 with wr_sel < 40 writes entry wr_sel.
REQ-029 wr_en=1 with wr_sel >= 40 SHALL write nothing and SHALL pulse sel_err the next cycle.
REQ-030 Index comparison SHALL use the full SEL_W bits; upper bits are not ignored.
REQ-031 If a stream write and a direct write target the same entry in the same cycle, the stream write SHALL win.
REQ-032 A stream write and a direct write to different entries in the same cycle SHALL both take effect.
REQ-033 A written value SHALL appear on its outN one cycle after the accepting edge; there is no combinational path from inputs to outN.

Reset
REQ-034 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, ptr=0, count=0, all outN=0, done=0, sel_err=0, busy=0 and s_ready=0.
REQ-035 Reset asserted mid-FILL SHALL abandon the fill without a done pulse and SHALL also clear entries already written.
REQ-036 Reset SHALL take priority over start, stream writes and direct writes.

Structure
REQ-037 Package demux40_pkg SHALL hold NUM_ENTRIES, DATA_W, SEL_W and the FSM state enum.
REQ-038 Sub-module demux40_decode SHALL be combinational and SHALL map (en, sel) to a NUM_ENTRIES-bit one-hot write enable plus an out-of-range flag.
REQ-039 demux40_decode SHALL be instantiated twice, once for the stream path and once for the direct path.

Verification
REQ-040 Reset, start, then stream 0x01..0x28 with s_valid held high -> out1=0x01 ... out40=0x28, done pulses once 41 cycles after start, count=40.
REQ-041 Direct write wr_sel=39, wr_data=0xA5 in IDLE -> out40=0xA5 next cycle; write wr_sel=40 -> no entry changes, sel_err pulses.
REQ-042 In FILL at ptr=5, stream 0x11 with direct write wr_sel=5, wr_data=0x22 in the same cycle -> out6=0x11.
REQ-043 Stream 10 bytes, pulse start, then stream 40 bytes of 0x55 -> all outN=0x55, done pulses once, count=40.
REQ-044 Assert rst_n=0 after 20 stream bytes -> all outputs 0, state IDLE, no done pulse; s_valid then held high -> s_ready stays 0.
REQ-045 Toggle s_valid randomly during a fill -> only the 40 accepted bytes are written, in order, with no skipped or duplicated entry.

Source files
------------

// File: rtl/demux40_pkg.sv
// demux40_pkg: shared sizing constants and FSM state encoding for the demux40 loader.
package demux40_pkg;
    localparam int NUM_ENTRIES = 40;
    localparam int DATA_W      = 8;
    localparam int SEL_W       = 16;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/demux40_decode.sv
// demux40_decode: combinational index decoder.
// Ports: en/sel in; we = one-hot write enable (NUM_ENTRIES bits), oor = en with sel out of range.
module demux40_decode #(
    parameter int NUM_ENTRIES = demux40_pkg::NUM_ENTRIES,
    parameter int SEL_W       = demux40_pkg::SEL_W
) (
    input  logic                   en,
    input  logic [SEL_W-1:0]       sel,
    output logic [NUM_ENTRIES-1:0] we,
    output logic                   oor
);
    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_we
        assign we[g] = en && sel == SEL_W'(g);
    end
    // full-width compare so nonzero upper select bits always count as out of range
    assign oor = en && sel >= SEL_W'(NUM_ENTRIES);
endmodule

// File: rtl/demux40_loader.sv
// demux40_loader: 40-entry byte register bank filled from a stream or by direct indexed writes.
// Ports: clk, rst_n (sync, active-low); start/s_valid/s_data/s_ready stream fill;
// wr_en/wr_sel/wr_data direct write; out1..out40 registered entries; busy, done, count, sel_err status.
module demux40_loader #(
    parameter int NUM_ENTRIES = demux40_pkg::NUM_ENTRIES,
    parameter int DATA_W      = demux40_pkg::DATA_W,
    parameter int SEL_W       = demux40_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9, out10,
    output logic [DATA_W-1:0] out11, out12, out13, out14, out15, out16, out17, out18, out19, out20,
    output logic [DATA_W-1:0] out21, out22, out23, out24, out25, out26, out27, out28, out29, out30,
    output logic [DATA_W-1:0] out31, out32, out33, out34, out35, out36, out37, out38, out39, out40,
    output logic              busy,
    output logic              done,
    output logic [5:0]        count,
    output logic              sel_err
);
    import demux40_pkg::*;

    localparam logic [5:0] LAST = 6'(NUM_ENTRIES - 1);

    state_t state, state_nx;
    logic accept, s_oor, wr_oor;
    logic [NUM_ENTRIES-1:0] s_we, wr_we;
    logic [DATA_W-1:0] ent [NUM_ENTRIES];

    assign accept  = state == FILL && s_valid;
    assign s_ready = state == FILL;
    assign busy    = state == FILL;
    assign done    = state == DONE;

    // count doubles as the fill pointer: both clear together and advance together
    demux40_decode #(.NUM_ENTRIES(NUM_ENTRIES), .SEL_W(SEL_W)) u_s_dec (
        .en(accept), .sel(SEL_W'(count)), .we(s_we), .oor(s_oor)
    );
    demux40_decode #(.NUM_ENTRIES(NUM_ENTRIES), .SEL_W(SEL_W)) u_wr_dec (
        .en(wr_en), .sel(wr_sel), .we(wr_we), .oor(wr_oor)
    );

    // a restart wins over completing on the last byte
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (start ? FILL : IDLE)
                 : state == FILL ? (start ? FILL : (accept && count == LAST) ? DONE : FILL)
                 : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                     count <= '0;
        else if (start && state != DONE) count <= '0;
        else if (accept)                count <= count + 6'd1;
    end

    always_ff @(posedge clk) begin
        sel_err <= rst_n && (wr_oor || s_oor);
    end

    // stream write has priority over a direct write to the same entry
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!rst_n)        ent[i] <= '0;
            else if (s_we[i])  ent[i] <= s_data;
            else if (wr_we[i]) ent[i] <= wr_data;
        end
    end

    assign out1  = ent[0];  assign out2  = ent[1];  assign out3  = ent[2];  assign out4  = ent[3];
    assign out5  = ent[4];  assign out6  = ent[5];  assign out7  = ent[6];  assign out8  = ent[7];
    assign out9  = ent[8];  assign out10 = ent[9];  assign out11 = ent[10]; assign out12 = ent[11];
    assign out13 = ent[12]; assign out14 = ent[13]; assign out15 = ent[14]; assign out16 = ent[15];
    assign out17 = ent[16]; assign out18 = ent[17]; assign out19 = ent[18]; assign out20 = ent[19];
    assign out21 = ent[20]; assign out22 = ent[21]; assign out23 = ent[22]; assign out24 = ent[23];
    assign out25 = ent[24]; assign out26 = ent[25]; assign out27 = ent[26]; assign out28 = ent[27];
    assign out29 = ent[28]; assign out30 = ent[29]; assign out31 = ent[30]; assign out32 = ent[31];
    assign out33 = ent[32]; assign out34 = ent[33]; assign out35 = ent[34]; assign out36 = ent[35];
    assign out37 = ent[36]; assign out38 = ent[37]; assign out39 = ent[38]; assign out40 = ent[39];
endmodule

// File: tb/tb_demux40_loader.sv
// tb_demux40_loader: directed self-checking bench for demux40_loader.
module tb_demux40_loader;
    logic clk = 0, rst_n = 0, start = 0, s_valid = 0, wr_en = 0;
    logic [7:0] s_data = 0, wr_data = 0;
    logic [15:0] wr_sel = 0;
    logic s_ready, busy, done, sel_err;
    logic [5:0] count;
    logic [7:0] o [40];
    logic [7:0] mem [40];
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    demux40_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .out1(o[0]), .out2(o[1]), .out3(o[2]), .out4(o[3]), .out5(o[4]),
        .out6(o[5]), .out7(o[6]), .out8(o[7]), .out9(o[8]), .out10(o[9]),
        .out11(o[10]), .out12(o[11]), .out13(o[12]), .out14(o[13]), .out15(o[14]),
        .out16(o[15]), .out17(o[16]), .out18(o[17]), .out19(o[18]), .out20(o[19]),
        .out21(o[20]), .out22(o[21]), .out23(o[22]), .out24(o[23]), .out25(o[24]),
        .out26(o[25]), .out27(o[26]), .out28(o[27]), .out29(o[28]), .out30(o[29]),
        .out31(o[30]), .out32(o[31]), .out33(o[32]), .out34(o[33]), .out35(o[34]),
        .out36(o[35]), .out37(o[36]), .out38(o[37]), .out39(o[38]), .out40(o[39]),
        .busy(busy), .done(done), .count(count), .sel_err(sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag);
        for (int i = 0; i < 40; i++) chk($sformatf("%s out%0d", tag, i + 1), 32'(o[i]), 32'(mem[i]));
    endtask

    initial begin
        int ndone, n, seen;
        logic acc, v;
        for (int i = 0; i < 40; i++) mem[i] = 8'h00;
        // reset state
        step; step;
        chk("rst busy", busy, 0); chk("rst done", done, 0); chk("rst ready", s_ready, 0);
        chk("rst count", count, 0); chk("rst sel_err", sel_err, 0);
        chk_outs("rst");
        rst_n = 1;
        // fill 0x01..0x28, done 41 cycles after start
        start = 1; step; start = 0;
        chk("fill busy", busy, 1); chk("fill ready", s_ready, 1); chk("fill count0", count, 0);
        s_valid = 1;
        for (int k = 1; k <= 40; k++) begin
            s_data = 8'(k); step; mem[k-1] = 8'(k);
            chk($sformatf("fill done@%0d", k), done, 32'(k == 40));
        end
        chk("fill count40", count, 40); chk("fill busy done", busy, 0); chk("fill ready done", s_ready, 0);
        // bytes and start offered in DONE are ignored
        s_data = 8'hEE; start = 1; step; start = 0; s_valid = 0;
        chk("done->idle done", done, 0); chk("done start ignored", busy, 0); chk("idle count hold", count, 40);
        chk_outs("fill");
        // direct writes in IDLE
        wr_en = 1; wr_sel = 16'd39; wr_data = 8'hA5; step; wr_en = 0; mem[39] = 8'hA5;
        chk("wr39 out40", o[39], 8'hA5); chk("wr39 sel_err", sel_err, 0);
        wr_en = 1; wr_sel = 16'd40; wr_data = 8'h77; step; wr_en = 0;
        chk("wr40 sel_err", sel_err, 1);
        chk_outs("wr40");
        step;
        chk("sel_err one pulse", sel_err, 0);
        wr_en = 1; wr_sel = 16'h0103; wr_data = 8'h77; step; wr_en = 0;
        chk("upper bits sel_err", sel_err, 1); chk("upper bits out4", o[3], mem[3]);
        // stream vs direct collisions
        start = 1; step; start = 0; s_valid = 1;
        for (int k = 0; k < 5; k++) begin
            s_data = 8'(8'h30 + k); step; mem[k] = 8'(8'h30 + k);
        end
        s_data = 8'h11; wr_en = 1; wr_sel = 16'd5; wr_data = 8'h22; step; mem[5] = 8'h11;
        chk("same idx out6", o[5], 8'h11); chk("same idx count", count, 6);
        s_data = 8'h12; wr_sel = 16'd0; wr_data = 8'h99; step; wr_en = 0; mem[6] = 8'h12; mem[0] = 8'h99;
        chk("diff idx out7", o[6], 8'h12); chk("diff idx out1", o[0], 8'h99); chk("diff idx count", count, 7);
        // restart with simultaneous accept writes the old ptr
        start = 1; s_data = 8'h66; step; start = 0; mem[7] = 8'h66;
        chk("restart out8", o[7], 8'h66); chk("restart count", count, 0); chk("restart busy", busy, 1);
        s_data = 8'h55; ndone = 0;
        for (int k = 0; k < 40; k++) begin
            step; mem[k] = 8'h55;
            if (done) ndone++;
        end
        s_valid = 0;
        for (int k = 0; k < 3; k++) begin
            step;
            if (done) ndone++;
        end
        chk("refill done pulses", ndone, 1); chk("refill count", count, 40);
        chk_outs("refill");
        // reset mid-fill
        start = 1; step; start = 0; s_valid = 1;
        for (int k = 0; k < 20; k++) begin
            s_data = 8'(8'h70 + k); step;
        end
        rst_n = 0; step; rst_n = 1;
        for (int i = 0; i < 40; i++) mem[i] = 8'h00;
        chk("midrst busy", busy, 0); chk("midrst count", count, 0); chk("midrst done", done, 0);
        chk("midrst ready", s_ready, 0); chk("midrst sel_err", sel_err, 0);
        for (int k = 0; k < 4; k++) begin
            step;
            chk($sformatf("post rst ready%0d", k), s_ready, 0);
            chk($sformatf("post rst done%0d", k), done, 0);
        end
        chk_outs("midrst");
        // random s_valid fill
        s_valid = 0; start = 1; step; start = 0;
        n = 0; seen = 0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            v = 1'($urandom_range(1, 0));
            s_valid = v; s_data = 8'(8'hC0 + n); acc = v && s_ready;
            step;
            if (acc) n++;
            if (done) seen = 1;
        end
        s_valid = 0;
        chk("rand done seen", seen, 1); chk("rand accepted", n, 40); chk("rand count", count, 40);
        for (int i = 0; i < 40; i++) mem[i] = 8'(8'hC0 + i);
        chk_outs("rand");
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
